inv_cipher_iterative: RTL

- Iterative AES inverse cipher (FIPS-197 §5.3 straightforward form); executes one decryption round per clock.
- Sits on the receive side, opposite the combinational encryption datapath.
- Consumes the same expanded key schedule `w` that encryption uses; key expansion is external.
- Start/done handshake toward the SPI front end; one block in flight at a time.

---
 rtl/inv_cipher_iterative.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/inv_cipher_iterative.sv
// inv_cipher_iterative: iterative AES inverse cipher, one decryption round per clock.
//
// Ports (top):
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          request, sampled only while idle
//   abort          (only with INV_CIPHER_ABORT_EN) drop the block in flight
//   Encrypted_Msg  ciphertext, captured on the accepting edge
//   w              expanded key schedule, round key r = w[r*128 +: 128]; hold stable while busy
//   busy           high from the accept edge until the done edge
//   done           one-cycle pulse when Decrypted_Msg is updated
//   Decrypted_Msg  registered plaintext, held until the next completion
//
// Build option: define INV_CIPHER_ABORT_EN to add the abort input.
// Submodules in this file: inv_shift_rows, inv_sub_bytes, inv_mix_columns, add_round_key.
// Byte i of a 128-bit state sits at bits [8*i +: 8]; column c holds bytes 4c..4c+3.

module inv_shift_rows (
  input  logic [0:127] istate,
  output logic [0:127] ostate
);
  // Row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign ostate[(r + 4*c)*8 +: 8] = istate[(r + 4*((c - r + 4) % 4))*8 +: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [0:127] istate,
  output logic [0:127] ostate
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then multiplicative inverse in GF(2^8) as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] s;
    logic [7:0] sq;
    logic [7:0] r;
    s  = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    sq = s;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign ostate[i*8 +: 8] = inv_sbox(istate[i*8 +: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [0:127] istate,
  output logic [0:127] ostate
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = istate[(4*c + 0)*8 +: 8];
    assign a1 = istate[(4*c + 1)*8 +: 8];
    assign a2 = istate[(4*c + 2)*8 +: 8];
    assign a3 = istate[(4*c + 3)*8 +: 8];
    assign ostate[(4*c + 0)*8 +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign ostate[(4*c + 1)*8 +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign ostate[(4*c + 2)*8 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign ostate[(4*c + 3)*8 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end
endmodule

module add_round_key (
  input  logic [0:127] istate,
  input  logic [0:127] key,
  output logic [0:127] ostate
);
  assign ostate = istate ^ key;
endmodule

// state | meaning
// IDLE  | waiting for start; done pulse (if any) clears here
// ROUND | full inverse round using round key rnd, rnd counts Nr-1 down to 1
// FINAL | last round without InvMixColumns, loads Decrypted_Msg
module inv_cipher_iterative #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
`ifdef INV_CIPHER_ABORT_EN
  input  logic                   abort,
`endif
  input  logic [0:127]           Encrypted_Msg,
  input  logic [0:128*(Nr+1)-1]  w,
  output logic                   busy,
  output logic                   done,
  output logic [0:127]           Decrypted_Msg
);
  localparam int RW = $clog2(Nr) + 1;
  localparam int WB = $clog2(128*(Nr+1));

  if (Nr != Nk + 6) begin : g_bad_nr
    $error("inv_cipher_iterative: Nr must equal Nk+6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t          fsm;
  logic [0:127]  st;
  logic [RW-1:0] rnd;
  logic [WB-1:0] rk_base;
  logic [0:127]  rk_sel;
  logic [0:127]  isr_out, isb_out, ark_out, imc_out;
  logic          start_ok;
  logic          abort_hit;

`ifdef INV_CIPHER_ABORT_EN
  assign start_ok  = start & ~abort;
  assign abort_hit = abort & busy;
`else
  assign start_ok  = start;
  assign abort_hit = 1'b0;
`endif

  assign rk_base = WB'({rnd, 7'b0000000});

  // FINAL always uses round key 0; rnd stays at 1 there.
  always_comb begin
    if (fsm == FINAL) rk_sel = w[0:127];
    else              rk_sel = w[rk_base +: 128];
  end

  inv_shift_rows  u_isr (.istate(st),      .ostate(isr_out));
  inv_sub_bytes   u_isb (.istate(isr_out), .ostate(isb_out));
  add_round_key   u_ark (.istate(isb_out), .key(rk_sel), .ostate(ark_out));
  inv_mix_columns u_imc (.istate(ark_out), .ostate(imc_out));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= IDLE;
      st            <= '0;
      rnd           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      Decrypted_Msg <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        fsm  <= IDLE;
        busy <= 1'b0;
      end else begin
        case (fsm)
          IDLE: begin
            if (start_ok) begin
              st   <= Encrypted_Msg ^ w[Nr*128 +: 128];
              rnd  <= RW'(Nr - 1);
              busy <= 1'b1;
              fsm  <= ROUND;
            end
          end
          ROUND: begin
            st <= imc_out;
            if (rnd == RW'(1)) fsm <= FINAL;
            else               rnd <= rnd - RW'(1);
          end
          FINAL: begin
            Decrypted_Msg <= ark_out;
            done          <= 1'b1;
            busy          <= 1'b0;
            fsm           <= IDLE;
          end
          default: begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
